// File: rtl/rv32m_sequencer.sv
// Execute-stage sequencer for the shared iterative RV32M multiplier and divider.
// Adds a one-cycle divide special-case path and a last-result cache in front of the units.
module rv32m_sequencer #(
  parameter bit CACHE_EN     = 1'b1,
  parameter bit FAST_PATH_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic [1:0]  req_sign,
  input  logic        req_high_low,
  input  logic        req_div_type,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [31:0] fu_op_a,
  output logic [31:0] fu_op_b,
  output logic        fu_signed_a,
  output logic        fu_signed_b,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic        div_start,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  typedef enum logic [2:0] {StIdle, StMulWait, StDivWait, StDone, StAbort} state_e;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic [31:0] fu_op_a_q, fu_op_a_d, fu_op_b_q, fu_op_b_d;
  logic        fu_signed_a_q, fu_signed_a_d, fu_signed_b_q, fu_signed_b_d;
  logic        mul_start_q, mul_start_d, div_start_q, div_start_d;
  logic        op_sel_hi_q, op_sel_hi_d, op_div_q, op_div_d;
  logic [1:0]  op_sign_q, op_sign_d;
  logic        cache_valid_q, cache_valid_d, cache_div_q, cache_div_d;
  logic [1:0]  cache_sign_q, cache_sign_d;
  logic [31:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [31:0] cache_hi_q, cache_hi_d, cache_lo_q, cache_lo_d;

  logic [1:0]  sign_n;
  logic        req_signed_a, req_signed_b, req_sel_hi;
  logic        cache_hit, div_by_zero, div_ovf, fast_path;
  logic [31:0] cache_word, fast_word;

  // Encoding 11 is illegal and behaves as unsigned x unsigned.
  assign sign_n       = (req_sign == 2'b11) ? 2'b01 : req_sign;
  assign req_signed_a = (sign_n != 2'b01);
  assign req_signed_b = (sign_n == 2'b00);
  assign req_sel_hi   = req_is_div ? req_div_type : req_high_low;

  assign cache_hit = CACHE_EN && cache_valid_q && (rs1_data == cache_a_q) &&
                     (rs2_data == cache_b_q) && (sign_n == cache_sign_q) &&
                     (req_is_div == cache_div_q);
  // Multiplies cache {hi, lo} of the product; divides cache {remainder, quotient}.
  assign cache_word = req_sel_hi ? cache_hi_q : cache_lo_q;

  assign div_by_zero = (rs2_data == 32'h0);
  assign div_ovf     = req_signed_a && req_signed_b && (rs1_data == 32'h8000_0000) &&
                       (rs2_data == 32'hFFFF_FFFF);
  assign fast_path   = FAST_PATH_EN && req_is_div && (div_by_zero || div_ovf);
  assign fast_word   = div_by_zero ? (req_div_type ? rs1_data : 32'hFFFF_FFFF)
                                   : (req_div_type ? 32'h0 : 32'h8000_0000);

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    fu_op_a_d     = fu_op_a_q;
    fu_op_b_d     = fu_op_b_q;
    fu_signed_a_d = fu_signed_a_q;
    fu_signed_b_d = fu_signed_b_q;
    mul_start_d   = 1'b0;
    div_start_d   = 1'b0;
    op_sel_hi_d   = op_sel_hi_q;
    op_div_d      = op_div_q;
    op_sign_d     = op_sign_q;
    cache_valid_d = cache_valid_q;
    cache_div_d   = cache_div_q;
    cache_sign_d  = cache_sign_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_hi_d    = cache_hi_q;
    cache_lo_d    = cache_lo_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          if (cache_hit) begin
            result_d = cache_word;
            state_d  = StDone;
          end else if (fast_path) begin
            result_d = fast_word;
            state_d  = StDone;
          end else begin
            fu_op_a_d     = rs1_data;
            fu_op_b_d     = rs2_data;
            fu_signed_a_d = req_signed_a;
            fu_signed_b_d = req_signed_b;
            op_sel_hi_d   = req_sel_hi;
            op_div_d      = req_is_div;
            op_sign_d     = sign_n;
            if (req_is_div) begin
              div_start_d = 1'b1;
              state_d     = StDivWait;
            end else begin
              mul_start_d = 1'b1;
              state_d     = StMulWait;
            end
          end
        end
      end
      StMulWait: begin
        if (mul_done) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            result_d      = op_sel_hi_q ? mul_product[63:32] : mul_product[31:0];
            cache_valid_d = 1'b1;
            cache_a_d     = fu_op_a_q;
            cache_b_d     = fu_op_b_q;
            cache_sign_d  = op_sign_q;
            cache_div_d   = 1'b0;
            cache_hi_d    = mul_product[63:32];
            cache_lo_d    = mul_product[31:0];
            state_d       = StDone;
          end
        end else if (flush) begin
          state_d = StAbort;
        end
      end
      StDivWait: begin
        if (div_done) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            result_d      = op_sel_hi_q ? div_remainder : div_quotient;
            cache_valid_d = 1'b1;
            cache_a_d     = fu_op_a_q;
            cache_b_d     = fu_op_b_q;
            cache_sign_d  = op_sign_q;
            cache_div_d   = 1'b1;
            cache_hi_d    = div_remainder;
            cache_lo_d    = div_quotient;
            state_d       = StDone;
          end
        end else if (flush) begin
          state_d = StAbort;
        end
      end
      StDone: state_d = StIdle;
      StAbort: begin
        // The unit cannot be cancelled; drain its done pulse before accepting again.
        if (op_div_q ? div_done : mul_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q       <= StIdle;
      result_q      <= '0;
      fu_op_a_q     <= '0;
      fu_op_b_q     <= '0;
      fu_signed_a_q <= 1'b0;
      fu_signed_b_q <= 1'b0;
      mul_start_q   <= 1'b0;
      div_start_q   <= 1'b0;
      op_sel_hi_q   <= 1'b0;
      op_div_q      <= 1'b0;
      op_sign_q     <= '0;
      cache_valid_q <= 1'b0;
      cache_div_q   <= 1'b0;
      cache_sign_q  <= '0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_hi_q    <= '0;
      cache_lo_q    <= '0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      fu_op_a_q     <= fu_op_a_d;
      fu_op_b_q     <= fu_op_b_d;
      fu_signed_a_q <= fu_signed_a_d;
      fu_signed_b_q <= fu_signed_b_d;
      mul_start_q   <= mul_start_d;
      div_start_q   <= div_start_d;
      op_sel_hi_q   <= op_sel_hi_d;
      op_div_q      <= op_div_d;
      op_sign_q     <= op_sign_d;
      cache_valid_q <= cache_valid_d;
      cache_div_q   <= cache_div_d;
      cache_sign_q  <= cache_sign_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_hi_q    <= cache_hi_d;
      cache_lo_q    <= cache_lo_d;
    end
  end

  assign result_valid = (state_q == StDone) && !flush;
  assign stall        = req_valid && !result_valid && !flush;
  assign result       = result_q;
  assign fu_op_a      = fu_op_a_q;
  assign fu_op_b      = fu_op_b_q;
  assign fu_signed_a  = fu_signed_a_q;
  assign fu_signed_b  = fu_signed_b_q;
  assign mul_start    = mul_start_q;
  assign div_start    = div_start_q;

endmodule

// File: tb/tb_rv32m_sequencer.sv
// Bench for rv32m_sequencer: directed table, hand-written flush/reset sequences and a
// randomized run checked against an arithmetic RV32M model with a last-result cache model.
module tb_rv32m_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid, req_is_div, req_high_low, req_div_type, flush;
  logic [1:0]  req_sign;
  logic [31:0] rs1_data, rs2_data;
  logic        stall, result_valid, fu_signed_a, fu_signed_b;
  logic [31:0] result, fu_op_a, fu_op_b;
  logic        mul_start, mul_done, div_start, div_done;
  logic [63:0] mul_product;
  logic [31:0] div_quotient, div_remainder;

  int n_checks = 0;
  int n_fail   = 0;
  int mul_lat  = 4;
  int div_lat  = 4;

  rv32m_sequencer dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_valid    (req_valid),
    .req_is_div   (req_is_div),
    .req_sign     (req_sign),
    .req_high_low (req_high_low),
    .req_div_type (req_div_type),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .fu_op_a      (fu_op_a),
    .fu_op_b      (fu_op_b),
    .fu_signed_a  (fu_signed_a),
    .fu_signed_b  (fu_signed_b),
    .mul_start    (mul_start),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .div_start    (div_start),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  always #5 CLK = ~CLK;

  // RV32M reference: sign 00 = s*s, 01 = u*u, 10 = s*u, 11 behaves as 01.
  function automatic logic [31:0] ref_result(input logic is_div, input logic [1:0] sign,
                                             input logic sel, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [1:0]         sn;
    logic [63:0]        ea, eb, p;
    logic signed [31:0] sa, sb;
    sn = (sign == 2'b11) ? 2'b01 : sign;
    if (!is_div) begin
      ea = (sn != 2'b01 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
      eb = (sn == 2'b00 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
      p  = ea * eb;
      return sel ? p[63:32] : p[31:0];
    end
    if (b == 32'h0) return sel ? a : 32'hFFFF_FFFF;
    if (sn == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return sel ? 32'h0 : 32'h8000_0000;
    if (sn == 2'b00) begin
      sa = a;
      sb = b;
      return sel ? 32'(sa % sb) : 32'(sa / sb);
    end
    return sel ? a % b : a / b;
  endfunction

  // Functional-unit models: done pulses a fixed number of cycles after the start pulse.
  int          mcnt, dcnt;
  logic [63:0] mprod;
  logic [31:0] dq, dr;
  always @(negedge CLK) begin
    if (!nRST) begin
      mcnt = 0; dcnt = 0; mul_done = 1'b0; div_done = 1'b0;
    end else begin
      mul_done = 1'b0;
      div_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin mul_done = 1'b1; mul_product = mprod; end
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_done = 1'b1; div_quotient = dq; div_remainder = dr;
        end
      end
      if (mul_start) begin
        mcnt  = mul_lat;
        mprod = (fu_signed_a && fu_op_a[31] ? {32'hFFFF_FFFF, fu_op_a} : {32'h0, fu_op_a}) *
                (fu_signed_b && fu_op_b[31] ? {32'hFFFF_FFFF, fu_op_b} : {32'h0, fu_op_b});
      end
      if (div_start) begin
        dcnt = div_lat;
        dq = ref_result(1'b1, fu_signed_a ? 2'b00 : 2'b01, 1'b0, fu_op_a, fu_op_b);
        dr = ref_result(1'b1, fu_signed_a ? 2'b00 : 2'b01, 1'b1, fu_op_a, fu_op_b);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Presents one request from an idle pipeline and waits (bounded) for result_valid.
  task automatic do_op(input logic is_div, input logic [1:0] sign, input logic sel,
                       input logic [31:0] a, input logic [31:0] b, output logic got,
                       output logic [31:0] res, output int starts, output int lat,
                       output logic timing_ok);
    int done_cyc;
    req_valid = 1'b1; req_is_div = is_div; req_sign = sign;
    req_high_low = sel; req_div_type = sel; rs1_data = a; rs2_data = b;
    got = 1'b0; res = '0; starts = 0; lat = 0; timing_ok = 1'b1; done_cyc = -10;
    for (int c = 1; c <= 200 && !got; c++) begin
      tick();
      if (mul_start || div_start) starts++;
      if (result_valid) begin
        got = 1'b1; res = result; lat = c;
        if (stall) timing_ok = 1'b0;
        if (starts != 0 && done_cyc != c - 1) timing_ok = 1'b0;
      end else if (!stall) begin
        timing_ok = 1'b0;
      end
      if (mul_done || div_done) done_cyc = c;
    end
    if (!got) $display("FAIL op timeout: got no result_valid, expected one within 200 cycles");
    req_valid = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " result_valid"}, 32'(result_valid), 32'h0);
    check({tag, " stall"}, 32'(stall), 32'h0);
    check({tag, " result"}, result, 32'h0);
    check({tag, " fu_op_a"}, fu_op_a, 32'h0);
    check({tag, " fu_op_b"}, fu_op_b, 32'h0);
    check({tag, " fu_signed"}, {30'h0, fu_signed_a, fu_signed_b}, 32'h0);
    check({tag, " starts"}, {30'h0, mul_start, div_start}, 32'h0);
  endtask

  task automatic apply_reset();
    nRST = 1'b0; req_valid = 1'b0; flush = 1'b0;
    repeat (3) tick();
    nRST = 1'b1;
    tick();
  endtask

  typedef struct {
    logic        is_div;
    logic [1:0]  sign;
    logic        sel;
    logic [31:0] a, b, exp;
    int          exp_starts;
  } vec_t;

  vec_t        vecs[12];
  logic        got, tok;
  logic [31:0] res;
  int          starts, lat, seen;

  // Cache model: last op that completed through a functional unit.
  logic        mc_valid, mc_div;
  logic [1:0]  mc_sign;
  logic [31:0] mc_a, mc_b;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_is_div = 1'b0; req_sign = 2'b00; req_high_low = 1'b0;
    req_div_type = 1'b0; rs1_data = '0; rs2_data = '0; flush = 1'b0;
    mul_product = '0; div_quotient = '0; div_remainder = '0;
    tick();
    apply_reset();
    check_reset_outputs("reset");

    // Flush two cycles after div_start, then the same DIVU must recompute.
    req_valid = 1'b1; req_is_div = 1'b1; req_sign = 2'b01; req_div_type = 1'b0;
    req_high_low = 1'b0; rs1_data = 32'd100; rs2_data = 32'd7; div_lat = 4; starts = 0;
    for (int c = 0; c < 10 && starts == 0; c++) begin
      tick();
      if (div_start) starts++;
    end
    check("abort first div_start", 32'(starts), 32'd1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0; seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (result_valid) seen++;
    end
    check("abort no result_valid", 32'(seen), 32'd0);
    do_op(1'b1, 2'b01, 1'b0, 32'd100, 32'd7, got, res, starts, lat, tok);
    check("after abort DIVU result", res, 32'd14);
    check("after abort div_start count", 32'(starts), 32'd1);

    // Reset while DIV_WAIT; the cached 100/7 must be forgotten.
    req_valid = 1'b1; req_is_div = 1'b1; req_sign = 2'b01; req_div_type = 1'b0;
    rs1_data = 32'd1000; rs2_data = 32'd3; div_lat = 6; starts = 0;
    for (int c = 0; c < 10 && starts == 0; c++) begin
      tick();
      if (div_start) starts++;
    end
    tick();
    nRST = 1'b0; req_valid = 1'b0;
    tick();
    check_reset_outputs("mid-op reset");
    nRST = 1'b1; seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (result_valid) seen++;
    end
    check("post reset no result_valid", 32'(seen), 32'd0);
    do_op(1'b1, 2'b01, 1'b0, 32'd100, 32'd7, got, res, starts, lat, tok);
    check("post reset 100/7 result", res, 32'd14);
    check("post reset 100/7 starts", 32'(starts), 32'd1);
    do_op(1'b1, 2'b01, 1'b0, 32'd1000, 32'd3, got, res, starts, lat, tok);
    check("post reset 1000/3 result", res, 32'd333);
    check("post reset 1000/3 starts", 32'(starts), 32'd1);

    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 0};
    vecs[3]  = '{1'b1, 2'b00, 1'b1, 32'd7, 32'd0, 32'd7, 0};
    vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[5]  = '{1'b1, 2'b00, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'd200, 32'd7, 32'd28, 1};
    vecs[7]  = '{1'b1, 2'b01, 1'b1, 32'd200, 32'd7, 32'd4, 0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1};
    vecs[9]  = '{1'b0, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'd5, 32'd6, 32'd30, 1};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 0};
    mul_lat = 4; div_lat = 5;
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].is_div, vecs[i].sign, vecs[i].sel, vecs[i].a, vecs[i].b,
            got, res, starts, lat, tok);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d start pulses", i), 32'(starts), 32'(vecs[i].exp_starts));
      if (vecs[i].exp_starts == 0) check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      else check($sformatf("vec%0d done-to-valid timing", i), 32'(tok), 32'd1);
    end

    apply_reset();
    mc_valid = 1'b0; mc_div = 1'b0; mc_sign = '0; mc_a = '0; mc_b = '0;
    for (int i = 0; i < 60; i++) begin
      logic        is_div, sel, hit, fast;
      logic [1:0]  sign, sn;
      logic [31:0] a, b;
      int          exp_starts;
      is_div = 1'($urandom_range(0, 1));
      sign   = is_div ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      sel    = 1'($urandom_range(0, 1));
      if (mc_valid && $urandom_range(0, 1) == 1) begin
        a = mc_a; b = mc_b;
      end else begin
        a = pick(); b = pick();
      end
      mul_lat = $urandom_range(1, 6);
      div_lat = $urandom_range(1, 6);
      sn   = (sign == 2'b11) ? 2'b01 : sign;
      hit  = mc_valid && a == mc_a && b == mc_b && sn == mc_sign && is_div == mc_div;
      fast = is_div && (b == 32'h0 || (sn == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_starts = (!hit && !fast) ? 1 : 0;
      do_op(is_div, sign, sel, a, b, got, res, starts, lat, tok);
      check($sformatf("rnd%0d result", i), res, ref_result(is_div, sign, sel, a, b));
      check($sformatf("rnd%0d start pulses", i), 32'(starts), 32'(exp_starts));
      if (exp_starts == 1) begin
        mc_valid = 1'b1; mc_a = a; mc_b = b; mc_sign = sn; mc_div = is_div;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
